// File: rtl/datapath_pipe_hs.sv
// Signed N-bit arithmetic datapath with 0..4 pipeline stages,
// valid/ready handshakes, optional saturation and an overflow counter.
module datapath_pipe_hs #(
  parameter int N      = 16,
  parameter int STAGES = 1,
  parameter int SAT    = 1,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     A,
  input  logic [N-1:0]     B,
  input  logic [2:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     Y,
  output logic             co,
  output logic             ov,
  input  logic             ov_clr,
  output logic [CNT_W-1:0] ov_cnt
);

  localparam int SHW = $clog2(N);
  localparam logic [N-1:0] MAXP = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] MINN = {1'b1, {(N-1){1'b0}}};

  logic [N-1:0]   y_d;
  logic           co_d;
  logic           ov_d;
  logic           pos_d;
  logic [N:0]     sum_w;
  logic [N:0]     dif_w;
  logic [N:0]     shl_w;
  logic [2*N-1:0] prod_w;
  logic [SHW-1:0] sh;

  always_comb begin
    sh     = B[SHW-1:0];
    sum_w  = {1'b0, A} + {1'b0, B};
    dif_w  = {1'b0, A} - {1'b0, B};
    prod_w = $signed({{N{A[N-1]}}, A}) *
             $signed({{N{B[N-1]}}, B});
    shl_w  = {1'b0, A} << sh;
    y_d    = '0;
    co_d   = 1'b0;
    ov_d   = 1'b0;
    pos_d  = 1'b0;
    unique case (opcode)
      3'b000: begin
        y_d   = sum_w[N-1:0];
        co_d  = sum_w[N];
        ov_d  = (A[N-1] == B[N-1]) &&
                (sum_w[N-1] != A[N-1]);
        pos_d = !A[N-1];
      end
      3'b001: begin
        y_d   = dif_w[N-1:0];
        co_d  = dif_w[N];
        ov_d  = (A[N-1] != B[N-1]) &&
                (dif_w[N-1] != A[N-1]);
        pos_d = !A[N-1];
      end
      3'b010: begin
        y_d   = prod_w[N-1:0];
        ov_d  = !((&prod_w[2*N-1:N-1]) ||
                  (~|prod_w[2*N-1:N-1]));
        pos_d = !prod_w[2*N-1];
      end
      3'b011: y_d = A & B;
      3'b100: y_d = A | B;
      3'b101: y_d = A ^ B;
      3'b110: begin
        y_d  = shl_w[N-1:0];
        co_d = shl_w[N];
      end
      3'b111: y_d = $signed(A) >>> sh;
    endcase
    // ov reports the wrapped result; clamping only touches Y
    if (SAT != 0 && ov_d)
      y_d = pos_d ? MAXP : MINN;
  end

  if (STAGES == 0) begin : g_comb
    assign out_valid = in_valid;
    assign in_ready  = out_ready;
    assign Y         = y_d;
    assign co        = co_d;
    assign ov        = ov_d;
  end else begin : g_pipe
    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] co_q;
    logic [STAGES-1:0] ov_q;
    logic [N-1:0]      y_q [STAGES];
    logic              en;

    assign en = !vld_q[STAGES-1] || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= '0;
        co_q  <= '0;
        ov_q  <= '0;
        for (int i = 0; i < STAGES; i++)
          y_q[i] <= '0;
      end else if (en) begin
        vld_q[0] <= in_valid;
        y_q[0]   <= y_d;
        co_q[0]  <= co_d;
        ov_q[0]  <= ov_d;
        for (int i = 1; i < STAGES; i++) begin
          vld_q[i] <= vld_q[i-1];
          y_q[i]   <= y_q[i-1];
          co_q[i]  <= co_q[i-1];
          ov_q[i]  <= ov_q[i-1];
        end
      end
    end

    assign in_ready  = en;
    assign out_valid = vld_q[STAGES-1];
    assign Y         = y_q[STAGES-1];
    assign co        = co_q[STAGES-1];
    assign ov        = ov_q[STAGES-1];
  end

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (ov_clr)
      cnt_d = '0;
    else if (out_valid && out_ready && ov && cnt_q != '1)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign ov_cnt = cnt_q;

endmodule

// File: tb/tb_datapath_pipe_hs.sv
// Directed bench for datapath_pipe_hs: two 2-stage instances
// (saturating and wrapping) and one combinational instance.
module tb_datapath_pipe_hs;
  localparam int N = 16;
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_ASR = 3'b111;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic ov_clr = 1'b0;
  logic [N-1:0] A = '0;
  logic [N-1:0] B = '0;
  logic [2:0] opcode = '0;

  logic ir2, ov_v2, co2, ov2;
  logic [N-1:0] y2;
  logic [7:0] cnt2;
  logic irw, ov_vw, cow, ovw;
  logic [N-1:0] yw;
  logic [7:0] cntw;
  logic ir0, ov_v0, co0, ov0;
  logic [N-1:0] y0;
  logic [7:0] cnt0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  datapath_pipe_hs #(.N(N), .STAGES(2), .SAT(1), .CNT_W(8)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir2),
    .A(A), .B(B), .opcode(opcode), .out_valid(ov_v2),
    .out_ready(out_ready), .Y(y2), .co(co2), .ov(ov2),
    .ov_clr(ov_clr), .ov_cnt(cnt2));

  datapath_pipe_hs #(.N(N), .STAGES(2), .SAT(0), .CNT_W(8)) uw (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(irw),
    .A(A), .B(B), .opcode(opcode), .out_valid(ov_vw),
    .out_ready(out_ready), .Y(yw), .co(cow), .ov(ovw),
    .ov_clr(ov_clr), .ov_cnt(cntw));

  datapath_pipe_hs #(.N(N), .STAGES(0), .SAT(1), .CNT_W(8)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0),
    .A(A), .B(B), .opcode(opcode), .out_valid(ov_v0),
    .out_ready(out_ready), .Y(y0), .co(co0), .ov(ov0),
    .ov_clr(ov_clr), .ov_cnt(cnt0));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op,
                       input logic [N-1:0] a,
                       input logic [N-1:0] b);
    opcode = op;
    A = a;
    B = b;
    in_valid = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    ov_clr = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if (ov_v2 !== 1'b0) begin
      failures++;
      $display("FAIL rst_out_valid got=%b exp=0", ov_v2);
    end
    checks++;
    if (y2 !== '0) begin
      failures++;
      $display("FAIL rst_y got=%h exp=0000", y2);
    end
    checks++;
    if ({co2, ov2, cnt2, ir2} !== {10'd0, 1'b1}) begin
      failures++;
      $display("FAIL rst_flags got=%b%b%h%b exp=0000001",
               co2, ov2, cnt2, ir2);
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_add_sat();
    do_reset();
    drive(OP_ADD, 16'h7fff, 16'h0001);
    step();
    in_valid = 1'b0;
    checks++;
    if (ov_v2 !== 1'b0) begin
      failures++;
      $display("FAIL add_early_valid got=%b exp=0", ov_v2);
    end
    step();
    checks++;
    if ({ov_v2, y2, ov2, co2} !== {1'b1, 16'h7fff, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL add_sat got=v%b y%h ov%b co%b exp=v1 y7fff ov1 co0",
               ov_v2, y2, ov2, co2);
    end
    checks++;
    if ({yw, ovw} !== {16'h8000, 1'b1}) begin
      failures++;
      $display("FAIL add_wrap got=y%h ov%b exp=y8000 ov1", yw, ovw);
    end
    step();
    checks++;
    if (cnt2 !== 8'd1) begin
      failures++;
      $display("FAIL add_ov_cnt got=%0d exp=1", cnt2);
    end
  endtask

  task automatic test_sub_mul();
    do_reset();
    drive(OP_SUB, 16'h0000, 16'h0001);
    step();
    drive(OP_MUL, 16'd300, 16'd300);
    step();
    drive(OP_MUL, 16'hfffd, 16'd7);
    checks++;
    if ({ov_v2, y2, co2, ov2} !== {1'b1, 16'hffff, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL sub got=v%b y%h co%b ov%b exp=v1 yffff co1 ov0",
               ov_v2, y2, co2, ov2);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if ({y2, ov2, co2} !== {16'h7fff, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL mul_sat got=y%h ov%b co%b exp=y7fff ov1 co0",
               y2, ov2, co2);
    end
    checks++;
    if (yw !== 16'h5f90) begin
      failures++;
      $display("FAIL mul_wrap got=%h exp=5f90", yw);
    end
    step();
    checks++;
    if ({ov_v2, y2, ov2, co2} !== {1'b1, 16'hffeb, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL mul_neg got=v%b y%h ov%b co%b exp=v1 yffeb ov0 co0",
               ov_v2, y2, ov2, co2);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] exp_y [6];
    int sent = 0;
    int recv = 0;
    int stalls = 0;
    for (int i = 0; i < 6; i++)
      exp_y[i] = N'(101 * (i + 1));
    do_reset();
    for (int c = 0; c < 30; c++) begin
      out_ready = !(c >= 3 && c <= 5);
      if (sent < 6)
        drive(OP_ADD, N'(100 * (sent + 1)), N'(sent + 1));
      else
        in_valid = 1'b0;
      @(negedge clk);
      if (ov_v2 && !out_ready) begin
        stalls++;
        checks++;
        if (ir2 !== 1'b0) begin
          failures++;
          $display("FAIL stall_in_ready cyc=%0d got=%b exp=0", c, ir2);
        end
        checks++;
        if (recv >= 6 || y2 !== exp_y[recv]) begin
          failures++;
          $display("FAIL stall_hold cyc=%0d got=%h idx=%0d", c, y2, recv);
        end
      end
      if (ov_v2 && out_ready) begin
        checks++;
        if (recv >= 6) begin
          failures++;
          $display("FAIL b2b_extra got=%h exp=none", y2);
        end else if (y2 !== exp_y[recv]) begin
          failures++;
          $display("FAIL b2b_order idx=%0d got=%h exp=%h",
                   recv, y2, exp_y[recv]);
        end
        recv++;
      end
      if (in_valid && ir2) sent++;
      step();
    end
    out_ready = 1'b1;
    checks++;
    if (recv !== 6) begin
      failures++;
      $display("FAIL b2b_count got=%0d exp=6", recv);
    end
    checks++;
    if (stalls !== 3) begin
      failures++;
      $display("FAIL b2b_stalls got=%0d exp=3", stalls);
    end
  endtask

  task automatic test_reset_midstream();
    int seen = 0;
    logic [N-1:0] first_y = '0;
    do_reset();
    drive(OP_ADD, 16'd1, 16'd1);
    step();
    drive(OP_ADD, 16'd2, 16'd2);
    step();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ov_v2, ov_vw} !== 2'b00) begin
      failures++;
      $display("FAIL mid_rst_valid got=%b%b exp=00", ov_v2, ov_vw);
    end
    step();
    rst_n = 1'b1;
    drive(OP_ADD, 16'd5, 16'd5);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (ov_v2) begin
        if (seen == 0) first_y = y2;
        seen++;
      end
      step();
      in_valid = 1'b0;
    end
    checks++;
    if (seen !== 1) begin
      failures++;
      $display("FAIL mid_rst_beats got=%0d exp=1", seen);
    end
    checks++;
    if (first_y !== 16'd10) begin
      failures++;
      $display("FAIL mid_rst_y got=%h exp=000a", first_y);
    end
  endtask

  task automatic test_comb();
    out_ready = 1'b1;
    drive(OP_ASR, 16'hfff0, 16'd2);
    #1;
    checks++;
    if ({ov_v0, y0} !== {1'b1, 16'hfffc}) begin
      failures++;
      $display("FAIL comb_asr got=v%b y%h exp=v1 yfffc", ov_v0, y0);
    end
    drive(OP_SHL, 16'h8001, 16'd1);
    #1;
    checks++;
    if ({y0, co0, ov0} !== {16'h0002, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL comb_shl got=y%h co%b ov%b exp=y0002 co1 ov0",
               y0, co0, ov0);
    end
    drive(OP_XOR, 16'hf0f0, 16'hff00);
    #1;
    checks++;
    if (y0 !== 16'h0ff0) begin
      failures++;
      $display("FAIL comb_xor got=%h exp=0ff0", y0);
    end
    drive(OP_AND, 16'hf0f0, 16'hff00);
    out_ready = 1'b0;
    #1;
    checks++;
    if ({y0, ir0} !== {16'hf000, 1'b0}) begin
      failures++;
      $display("FAIL comb_and_rdy got=y%h r%b exp=yf000 r0", y0, ir0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
  endtask

  task automatic test_ov_cnt();
    do_reset();
    drive(OP_ADD, 16'h7fff, 16'h0001);
    repeat (255) step();
    in_valid = 1'b0;
    repeat (4) step();
    checks++;
    if ({cnt2, cntw} !== {8'd255, 8'd255}) begin
      failures++;
      $display("FAIL cnt_255 got=%0d/%0d exp=255", cnt2, cntw);
    end
    drive(OP_ADD, 16'h7fff, 16'h0001);
    step();
    step();
    in_valid = 1'b0;
    repeat (4) step();
    checks++;
    if (cnt2 !== 8'd255) begin
      failures++;
      $display("FAIL cnt_sat got=%0d exp=255", cnt2);
    end
    drive(OP_ADD, 16'h7fff, 16'h0001);
    step();
    in_valid = 1'b0;
    step();
    ov_clr = 1'b1;
    step();
    ov_clr = 1'b0;
    checks++;
    if (cnt2 !== 8'd0) begin
      failures++;
      $display("FAIL cnt_clr_prio got=%0d exp=0", cnt2);
    end
    drive(OP_SUB, 16'h8000, 16'h0001);
    step();
    in_valid = 1'b0;
    repeat (3) step();
    checks++;
    if (cnt2 !== 8'd1) begin
      failures++;
      $display("FAIL cnt_after_clr got=%0d exp=1", cnt2);
    end
  endtask

  initial begin
    test_reset();
    test_add_sat();
    test_sub_mul();
    test_back_to_back();
    test_reset_midstream();
    test_comb();
    test_ov_cnt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
